// File: rtl/bp_be_ptw_result_queue_if.sv
// bp_be_ptw_result_queue_if
//   Bundles the page-table-walker result beat, the flush, and the three
//   consumer handshakes (DTLB write port, frontend command path, exception
//   path) of bp_be_ptw_result_queue.
//   master : the surroundings (walker, flush source, consumers)
//   slave  : the result queue itself
interface bp_be_ptw_result_queue_if
  #(parameter int vaddr_width_p    = 39
   ,parameter int pte_leaf_width_p = 64
   ,parameter int fetch_ptr_gp     = 3
   ,parameter int dword_width_gp   = 64
   );

   // walker result beat
   logic                        v_i;
   logic                        walk_i;
   logic                        itlb_fill_i;
   logic                        dtlb_fill_i;
   logic                        instr_page_fault_i;
   logic                        load_page_fault_i;
   logic                        store_page_fault_i;
   logic [fetch_ptr_gp-1:0]     count_i;
   logic [dword_width_gp-1:0]   addr_i;
   logic [pte_leaf_width_p-1:0] pte_i;
   logic                        flush_i;
   logic                        ready_o;
   logic                        overflow_o;

   // DTLB write port
   logic                        dtlb_v_o;
   logic                        dtlb_yumi_i;
   logic [vaddr_width_p-1:0]    dtlb_vaddr_o;
   logic [pte_leaf_width_p-1:0] dtlb_pte_o;

   // frontend command path
   logic                        fe_v_o;
   logic                        fe_ready_and_i;
   logic                        fe_fault_o;
   logic [fetch_ptr_gp-1:0]     fe_count_o;
   logic [vaddr_width_p-1:0]    fe_vaddr_o;
   logic [pte_leaf_width_p-1:0] fe_pte_o;

   // exception path
   logic                        exc_v_o;
   logic                        exc_yumi_i;
   logic                        exc_store_o;
   logic [vaddr_width_p-1:0]    exc_vaddr_o;

   modport master
     (output v_i, walk_i, itlb_fill_i, dtlb_fill_i, instr_page_fault_i
     ,output load_page_fault_i, store_page_fault_i, count_i, addr_i, pte_i, flush_i
     ,output dtlb_yumi_i, fe_ready_and_i, exc_yumi_i
     ,input  ready_o, overflow_o
     ,input  dtlb_v_o, dtlb_vaddr_o, dtlb_pte_o
     ,input  fe_v_o, fe_fault_o, fe_count_o, fe_vaddr_o, fe_pte_o
     ,input  exc_v_o, exc_store_o, exc_vaddr_o
     );

   modport slave
     (input  v_i, walk_i, itlb_fill_i, dtlb_fill_i, instr_page_fault_i
     ,input  load_page_fault_i, store_page_fault_i, count_i, addr_i, pte_i, flush_i
     ,input  dtlb_yumi_i, fe_ready_and_i, exc_yumi_i
     ,output ready_o, overflow_o
     ,output dtlb_v_o, dtlb_vaddr_o, dtlb_pte_o
     ,output fe_v_o, fe_fault_o, fe_count_o, fe_vaddr_o, fe_pte_o
     ,output exc_v_o, exc_store_o, exc_vaddr_o
     );

endinterface

// File: rtl/bp_be_ptw_result_queue.sv
// bp_be_ptw_result_queue
//   Captures completed page-table-walk results (walk beats are filtered out)
//   into an in-order circular buffer and steers the head entry to the DTLB
//   write port, the frontend command path, or the exception path.
//   Ports:
//     clk_i     - sole clock
//     reset_n_i - asynchronous active-low reset
//     io        - bp_be_ptw_result_queue_if.slave (walker beat, flush,
//                 ready/overflow status and the three consumer handshakes)
//   Optional feature: define BP_PTW_RESULT_BYPASS_EN to let a beat arriving
//   at an empty queue be presented to its consumer in the same cycle.
//   Default build: one-cycle latency, outputs depend on registered state only.
module bp_be_ptw_result_queue
  #(parameter int vaddr_width_p    = 39
   ,parameter int els_p            = 2
   ,parameter int pte_leaf_width_p = 64
   ,parameter int fetch_ptr_gp     = 3
   ,parameter int dword_width_gp   = 64
   ,localparam int lg_els_lp       = (els_p == 1) ? 1 : $clog2(els_p)
   )
  (input logic                    clk_i
  ,input logic                    reset_n_i
  ,bp_be_ptw_result_queue_if.slave io
  );

   typedef enum logic [1:0] {
      cls_dtlb = 2'd0,
      cls_fe   = 2'd1,
      cls_exc  = 2'd2
   } cls_e;

   typedef struct packed {
      cls_e                        cls;
      logic                        fault;
      logic                        store;
      logic [fetch_ptr_gp-1:0]     count;
      logic [vaddr_width_p-1:0]    vaddr;
      logic [pte_leaf_width_p-1:0] pte;
   } entry_s;

   localparam logic [lg_els_lp-1:0] ptr_one_lp  = lg_els_lp'(1);
   localparam logic [lg_els_lp-1:0] ptr_last_lp = lg_els_lp'(els_p - 1);
   localparam logic [lg_els_lp:0]   cnt_one_lp  = (lg_els_lp + 1)'(1);
   localparam logic [lg_els_lp:0]   cnt_full_lp = (lg_els_lp + 1)'(els_p);

   entry_s                mem [els_p];
   logic [lg_els_lp-1:0]  rptr, wptr;
   logic [lg_els_lp:0]    cnt;
   logic                  overflow;

   entry_s                in_entry, head;
   logic                  enq, full, empty, bypass, head_v;
   logic                  deq, deq_mem, accept, drop;

   // Pointers wrap explicitly so non-power-of-two depths work.
   function automatic logic [lg_els_lp-1:0] ptr_inc(input logic [lg_els_lp-1:0] p);
      return (p == ptr_last_lp) ? '0 : p + ptr_one_lp;
   endfunction

   assign enq   = io.v_i & ~io.walk_i
                & (io.itlb_fill_i | io.dtlb_fill_i | io.instr_page_fault_i
                   | io.load_page_fault_i | io.store_page_fault_i);
   assign full  = (cnt == cnt_full_lp);
   assign empty = (cnt == '0);

   // Classification: a DTLB fill wins, then frontend, then exception.
   always_comb begin
      in_entry       = '0;
      in_entry.count = io.count_i;
      in_entry.vaddr = io.addr_i[vaddr_width_p-1:0];
      in_entry.pte   = io.pte_i;
      if (io.dtlb_fill_i) begin
         in_entry.cls = cls_dtlb;
      end else if (io.itlb_fill_i | io.instr_page_fault_i) begin
         in_entry.cls   = cls_fe;
         in_entry.fault = io.instr_page_fault_i;
      end else begin
         in_entry.cls   = cls_exc;
         in_entry.store = io.store_page_fault_i;
      end
   end

`ifdef BP_PTW_RESULT_BYPASS_EN
   assign bypass = empty & enq & ~io.flush_i;
   assign head   = bypass ? in_entry : mem[rptr];
`else
   assign bypass = 1'b0;
   assign head   = mem[rptr];
`endif

   assign head_v = ~empty | bypass;

   assign io.dtlb_v_o     = head_v & (head.cls == cls_dtlb);
   assign io.dtlb_vaddr_o = head.vaddr;
   assign io.dtlb_pte_o   = head.pte;
   assign io.fe_v_o       = head_v & (head.cls == cls_fe);
   assign io.fe_fault_o   = head.fault;
   assign io.fe_count_o   = head.count;
   assign io.fe_vaddr_o   = head.vaddr;
   assign io.fe_pte_o     = head.pte;
   assign io.exc_v_o      = head_v & (head.cls == cls_exc);
   assign io.exc_store_o  = head.store;
   assign io.exc_vaddr_o  = head.vaddr;
   assign io.ready_o      = ~full;
   assign io.overflow_o   = overflow;

   assign deq     = (io.dtlb_v_o & io.dtlb_yumi_i)
                  | (io.fe_v_o   & io.fe_ready_and_i)
                  | (io.exc_v_o  & io.exc_yumi_i);
   // A handshake on a bypassed beat consumes the incoming beat, not storage.
   assign deq_mem = deq & ~empty;
   // A full queue frees a slot for the incoming beat when the head leaves now.
   assign accept  = enq & (~full | deq_mem) & ~io.flush_i & ~(bypass & deq);
   // A flush discards the beat on purpose; that is not a capacity loss.
   assign drop    = enq & full & ~deq_mem & ~io.flush_i;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rptr     <= '0;
         wptr     <= '0;
         cnt      <= '0;
         overflow <= 1'b0;
      end else begin
         if (drop) overflow <= 1'b1;
         if (io.flush_i) begin
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
         end else begin
            if (deq_mem) rptr <= ptr_inc(rptr);
            if (accept)  wptr <= ptr_inc(wptr);
            case ({accept, deq_mem})
               2'b10:   cnt <= cnt + cnt_one_lp;
               2'b01:   cnt <= cnt - cnt_one_lp;
               default: cnt <= cnt;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int i = 0; i < els_p; i++) mem[i] <= '0;
      end else if (accept) begin
         mem[wptr] <= in_entry;
      end
   end

   // Upper address bits beyond the virtual address width are not stored.
   logic unused_addr_bits;
   assign unused_addr_bits = ^io.addr_i[dword_width_gp-1:vaddr_width_p];

endmodule

// File: tb/tb_bp_be_ptw_result_queue.sv
module tb_bp_be_ptw_result_queue;

   localparam int VA  = 39;
   localparam int PTE = 44;
   localparam int FP  = 3;
   localparam int DW  = 64;

   typedef struct {
      int              cls;   // 0 dtlb, 1 fe, 2 exc
      logic            fault;
      logic            store;
      logic [FP-1:0]   count;
      logic [VA-1:0]   vaddr;
      logic [PTE-1:0]  pte;
   } exp_t;

   logic clk;
   logic reset_n;
   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];

   bp_be_ptw_result_queue_if #(.vaddr_width_p(VA), .pte_leaf_width_p(PTE)
                              ,.fetch_ptr_gp(FP), .dword_width_gp(DW)) bus();

   bp_be_ptw_result_queue #(.vaddr_width_p(VA), .els_p(2), .pte_leaf_width_p(PTE)
                           ,.fetch_ptr_gp(FP), .dword_width_gp(DW))
     dut (.clk_i(clk), .reset_n_i(reset_n), .io(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_empty(input string tag);
      chk({tag, "_dtlb_v"}, bus.dtlb_v_o, 1'b0);
      chk({tag, "_fe_v"},   bus.fe_v_o,   1'b0);
      chk({tag, "_exc_v"},  bus.exc_v_o,  1'b0);
   endtask

   task automatic drive_beat(input int cls, input logic fault, input logic store,
                             input logic [63:0] addr, input logic [PTE-1:0] pte,
                             input logic [FP-1:0] cnt);
      bus.v_i                = 1'b1;
      bus.walk_i             = 1'b0;
      bus.dtlb_fill_i        = (cls == 0);
      bus.itlb_fill_i        = (cls == 1) && !fault;
      bus.instr_page_fault_i = (cls == 1) && fault;
      bus.load_page_fault_i  = (cls == 2) && !store;
      bus.store_page_fault_i = (cls == 2) && store;
      bus.addr_i             = addr;
      bus.pte_i              = pte;
      bus.count_i            = cnt;
   endtask

   task automatic idle_beat();
      bus.v_i                = 1'b0;
      bus.walk_i             = 1'b0;
      bus.dtlb_fill_i        = 1'b0;
      bus.itlb_fill_i        = 1'b0;
      bus.instr_page_fault_i = 1'b0;
      bus.load_page_fault_i  = 1'b0;
      bus.store_page_fault_i = 1'b0;
   endtask

   task automatic push_exp(input int cls, input logic fault, input logic store,
                           input logic [63:0] addr, input logic [PTE-1:0] pte,
                           input logic [FP-1:0] cnt);
      exp_t e;
      e.cls   = cls;
      e.fault = (cls == 1) ? fault : 1'b0;
      e.store = (cls == 2) ? store : 1'b0;
      e.count = cnt;
      e.vaddr = addr[VA-1:0];
      e.pte   = pte;
      sb.push_back(e);
   endtask

   task automatic send(input int cls, input logic fault, input logic store,
                       input logic [63:0] addr, input logic [PTE-1:0] pte,
                       input logic [FP-1:0] cnt, input bit acc);
      drive_beat(cls, fault, store, addr, pte, cnt);
      @(negedge clk);
      idle_beat();
      if (acc) push_exp(cls, fault, store, addr, pte, cnt);
   endtask

   // Compare the presented head against the scoreboard front (no handshake).
   task automatic check_head(input string tag);
      exp_t e;
      bit   vis;
      vis = 1'b0;
      if (sb.size() == 0) begin
         chk({tag, "_sb_nonempty"}, 1'b0, 1'b1);
      end else begin
         e = sb[0];
         for (int i = 0; i < 20; i++) begin
            vis = (e.cls == 0) ? bus.dtlb_v_o : (e.cls == 1) ? bus.fe_v_o : bus.exc_v_o;
            if (vis) break;
            @(negedge clk);
         end
         chk({tag, "_visible"}, vis, 1'b1);
         chk({tag, "_one_hot"}, {61'b0, bus.dtlb_v_o, bus.fe_v_o, bus.exc_v_o},
             {61'b0, e.cls == 0, e.cls == 1, e.cls == 2});
         case (e.cls)
            0: begin
               chk({tag, "_dtlb_vaddr"}, bus.dtlb_vaddr_o, e.vaddr);
               chk({tag, "_dtlb_pte"},   bus.dtlb_pte_o,   e.pte);
            end
            1: begin
               chk({tag, "_fe_fault"}, bus.fe_fault_o, e.fault);
               chk({tag, "_fe_count"}, bus.fe_count_o, e.count);
               chk({tag, "_fe_vaddr"}, bus.fe_vaddr_o, e.vaddr);
               chk({tag, "_fe_pte"},   bus.fe_pte_o,   e.pte);
            end
            default: begin
               chk({tag, "_exc_store"}, bus.exc_store_o, e.store);
               chk({tag, "_exc_vaddr"}, bus.exc_vaddr_o, e.vaddr);
            end
         endcase
      end
   endtask

   task automatic consume(input string tag);
      int cls;
      check_head(tag);
      if (sb.size() != 0) begin
         cls = sb[0].cls;
         if (cls == 0) bus.dtlb_yumi_i = 1'b1;
         else if (cls == 1) bus.fe_ready_and_i = 1'b1;
         else bus.exc_yumi_i = 1'b1;
         @(negedge clk);
         bus.dtlb_yumi_i    = 1'b0;
         bus.fe_ready_and_i = 1'b0;
         bus.exc_yumi_i     = 1'b0;
         void'(sb.pop_front());
      end
   endtask

   initial begin
      reset_n            = 1'b0;
      idle_beat();
      bus.count_i        = '0;
      bus.addr_i         = '0;
      bus.pte_i          = '0;
      bus.flush_i        = 1'b0;
      bus.dtlb_yumi_i    = 1'b0;
      bus.fe_ready_and_i = 1'b0;
      bus.exc_yumi_i     = 1'b0;

      // reset state
      repeat (2) @(negedge clk);
      chk_empty("rst");
      chk("rst_ready", bus.ready_o, 1'b1);
      chk("rst_ovf", bus.overflow_o, 1'b0);
      reset_n = 1'b1;
      @(negedge clk);

      // walk filtering: walk beats carrying fill flags are not results
      for (int i = 0; i < 3; i++) begin
         drive_beat(0, 1'b0, 1'b0, 64'h8000_2000, 44'h111, 3'd0);
         bus.walk_i = 1'b1;
         @(negedge clk);
         chk_empty("walk");
         chk("walk_ready", bus.ready_o, 1'b1);
      end
      idle_beat();
      send(0, 1'b0, 1'b0, 64'h8000_1000, 44'hABC_DEF, 3'd0, 1'b1);
      chk("walk_dtlb_v_lat1", bus.dtlb_v_o, 1'b1);
      consume("walk_dtlb");
      chk_empty("walk_after");

      // steering and ordering: blocked FE head holds back a DTLB fill
      send(1, 1'b1, 1'b0, 64'h2000, 44'h5A5, 3'd5, 1'b1);
      send(0, 1'b0, 1'b0, 64'h3000, 44'h777, 3'd0, 1'b1);
      chk("steer_full_ready", bus.ready_o, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("steer_dtlb_blocked", bus.dtlb_v_o, 1'b0);
         chk("steer_fe_v", bus.fe_v_o, 1'b1);
      end
      consume("steer_fe");
      chk("steer_dtlb_next", bus.dtlb_v_o, 1'b1);
      consume("steer_dtlb");
      chk_empty("steer_after");

      // full boundary: enq with same-cycle deq is accepted, without deq dropped
      send(2, 1'b0, 1'b0, 64'hA00, 44'h0, 3'd0, 1'b1);
      send(2, 1'b0, 1'b1, 64'hB00, 44'h0, 3'd0, 1'b1);
      chk("full_ready", bus.ready_o, 1'b0);
      check_head("full_headA");
      drive_beat(2, 1'b0, 1'b1, 64'hD00, 44'h0, 3'd0);
      bus.exc_yumi_i = 1'b1;
      @(negedge clk);
      idle_beat();
      bus.exc_yumi_i = 1'b0;
      void'(sb.pop_front());
      push_exp(2, 1'b0, 1'b1, 64'hD00, 44'h0, 3'd0);
      chk("full_swap_ovf", bus.overflow_o, 1'b0);
      chk("full_swap_ready", bus.ready_o, 1'b0);
      send(2, 1'b0, 1'b1, 64'hC00, 44'h0, 3'd0, 1'b0);
      chk("full_drop_ovf", bus.overflow_o, 1'b1);
      consume("full_B");
      consume("full_D");
      chk_empty("full_after");
      chk("full_ovf_sticky", bus.overflow_o, 1'b1);

      // wrap-around through both slots several times
      for (int i = 1; i <= 5; i++) begin
         send(2, 1'b0, 1'b0, 64'(i) << 8, 44'h0, 3'd0, 1'b1);
         consume("wrap");
      end
      chk_empty("wrap_after");

      // flush collision: head consumed, rest flushed, incoming beat discarded
      send(0, 1'b0, 1'b0, 64'hE000, 44'hE, 3'd0, 1'b1);
      send(0, 1'b0, 1'b0, 64'hF000, 44'hF, 3'd0, 1'b1);
      check_head("flush_headE");
      drive_beat(0, 1'b0, 1'b0, 64'h9000, 44'h9, 3'd0);
      bus.dtlb_yumi_i = 1'b1;
      bus.flush_i     = 1'b1;
      @(negedge clk);
      idle_beat();
      bus.dtlb_yumi_i = 1'b0;
      bus.flush_i     = 1'b0;
      sb.delete();
      chk_empty("flush_next");
      chk("flush_ready", bus.ready_o, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("flush_never_presented", bus.dtlb_v_o, 1'b0);
      end

      // reset mid-traffic, asserted between clock edges
      send(2, 1'b0, 1'b0, 64'h700, 44'h0, 3'd0, 1'b1);
      send(0, 1'b0, 1'b0, 64'h800, 44'h8, 3'd0, 1'b1);
      chk("mid_full", bus.ready_o, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      chk_empty("mid_rst");
      chk("mid_rst_ovf", bus.overflow_o, 1'b0);
      chk("mid_rst_ready", bus.ready_o, 1'b1);
      #1 reset_n = 1'b1;
      sb.delete();
      @(negedge clk);
      chk_empty("mid_after");
      chk("mid_after_ready", bus.ready_o, 1'b1);
      send(1, 1'b0, 1'b0, 64'h4440, 44'h44, 3'd2, 1'b1);
      consume("mid_alive");
      chk_empty("end");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
